// File: rtl/cic_comp_fir.sv
// cic_comp_fir: serial-MAC CIC droop compensation FIR, decimate by 1 or 2.
// Optional output saturation: define CIC_COMP_SAT_EN (default build wraps).
`timescale 1ns/1ps
module cic_comp_fir #(
  parameter int IN_WIDTH    = 24,
  parameter int OUT_WIDTH   = 24,
  parameter int COEFF_WIDTH = 18,
  parameter int TAPS        = 32,
  parameter int DECIM       = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_strobe,
  input  logic signed [IN_WIDTH-1:0]    in_data,
  input  logic                          coef_wr,
  input  logic [$clog2(TAPS)-1:0]       coef_addr,
  input  logic signed [COEFF_WIDTH-1:0] coef_data,
  input  logic                          overrun_clr,
  output logic                          out_strobe,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic                          busy,
  output logic                          overrun
);

  localparam int AW  = $clog2(TAPS);
  localparam int BUF = 2 * TAPS;
  localparam int BW  = AW + 1;
  localparam int PW  = IN_WIDTH + COEFF_WIDTH;
  localparam int ACW = PW + AW;
  localparam int CW  = AW + 2;
  localparam int PHW = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic [1:0] {CLEAR, IDLE, RUN, DONE} state_t;

  logic signed [IN_WIDTH-1:0]    xbuf [BUF];
  logic signed [COEFF_WIDTH-1:0] coef [TAPS];

  state_t            state;
  logic [BW-1:0]     clr_cnt;
  logic [BW-1:0]     wp;
  logic [PHW-1:0]    phase;
  logic              pend;
  logic [BW-1:0]     pend_base;
  logic [BW-1:0]     base;
  logic [CW-1:0]     cnt;

  logic              trig;
  logic              drop;
  logic              rd_en;
  logic [BW-1:0]     rd_addr;

  logic signed [IN_WIDTH-1:0]    x_q;
  logic signed [COEFF_WIDTH-1:0] c_q;
  logic signed [PW-1:0]          prod;
  logic signed [ACW-1:0]         acc;
  logic signed [ACW-1:0]         shifted;
  logic signed [OUT_WIDTH-1:0]   res;
  logic v1, f1, v2, f2;

  assign trig = in_strobe && (state != CLEAR)
             && (phase == PHW'(DECIM - 1));
  assign drop = trig && pend
             && ((state == RUN) || (state == DONE));
  assign rd_en   = (state == RUN) && (cnt < CW'(TAPS));
  assign rd_addr = base - {1'b0, cnt[AW-1:0]};
  assign busy    = (state != IDLE);
  assign shifted = acc >>> (COEFF_WIDTH - 1);

`ifdef CIC_COMP_SAT_EN
  localparam int HW = ACW - OUT_WIDTH + 1;
  logic [HW-1:0] hi;
  assign hi = shifted[ACW-1:OUT_WIDTH-1];

  // clamp results that do not fit the output width
  always_comb begin
    res = shifted[OUT_WIDTH-1:0];
    if (hi != '0 && hi != '1) begin
      if (shifted[ACW-1])
        res = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else
        res = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^shifted[ACW-1:OUT_WIDTH];

  // two's complement wrap: keep the low output bits
  always_comb begin
    res = shifted[OUT_WIDTH-1:0];
  end
`endif

  // sample buffer: zero fill during CLEAR, else capture samples
  always_ff @(posedge clock) begin
    if (state == CLEAR)
      xbuf[clr_cnt] <= '0;
    else if (in_strobe)
      xbuf[wp] <= in_data;
  end

  // coefficient store, writable at any time, never cleared
  always_ff @(posedge clock) begin
    if (coef_wr)
      coef[coef_addr] <= coef_data;
  end

  // datapath: RAM read stage then multiply stage
  always_ff @(posedge clock) begin
    x_q  <= xbuf[rd_addr];
    c_q  <= coef[cnt[AW-1:0]];
    prod <= PW'(x_q) * PW'(c_q);
  end

  // tap-valid pipeline and accumulator (first product reloads)
  always_ff @(posedge clock) begin
    if (reset) begin
      v1  <= 1'b0;
      f1  <= 1'b0;
      v2  <= 1'b0;
      f2  <= 1'b0;
      acc <= '0;
    end else begin
      v1 <= rd_en;
      f1 <= rd_en && (cnt == '0);
      v2 <= v1;
      f2 <= f1;
      if (v2)
        acc <= f2 ? ACW'(prod) : acc + ACW'(prod);
    end
  end

  // control FSM: clear, tap sequencing, output, pending, overrun
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      wp         <= '0;
      phase      <= '0;
      pend       <= 1'b0;
      pend_base  <= '0;
      base       <= '0;
      cnt        <= '0;
      out_strobe <= 1'b0;
      out_data   <= '0;
      overrun    <= 1'b0;
    end else begin
      out_strobe <= 1'b0;
      if (drop)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
      if (in_strobe && state != CLEAR) begin
        wp <= wp + BW'(1);
        if (phase == PHW'(DECIM - 1))
          phase <= '0;
        else
          phase <= phase + PHW'(1);
      end
      unique case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + BW'(1);
          if (clr_cnt == BW'(BUF - 1))
            state <= IDLE;
        end
        IDLE: begin
          if (trig) begin
            state <= RUN;
            base  <= wp;
            cnt   <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (trig && !pend) begin
            pend      <= 1'b1;
            pend_base <= wp;
          end
          if (cnt == CW'(TAPS + 2)) begin
            state      <= DONE;
            out_strobe <= 1'b1;
            out_data   <= res;
          end
        end
        DONE: begin
          cnt <= '0;
          if (pend) begin
            state <= RUN;
            base  <= pend_base;
            pend  <= 1'b0;
          end else if (trig) begin
            state <= RUN;
            base  <= wp;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// tb_cic_comp_fir: scoreboard bench, one DUT per decimation (1 and 2).
// Expected samples come from a direct convolution over the input history.
`timescale 1ns/1ps
module tb_cic_comp_fir;

  localparam int TAPS = 32;
  localparam int CWD  = 18;

  typedef struct {
    logic [23:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 0;
  logic        reset = 0;
  logic        in_strobe = 0;
  logic [23:0] in_data = '0;
  logic        coef_wr = 0;
  logic [4:0]  coef_addr = '0;
  logic [17:0] coef_data = '0;
  logic        overrun_clr = 0;

  logic        os   [2];
  logic [23:0] od   [2];
  logic        busy [2];
  logic        ov   [2];

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     clear_end = 0;
  int     mcoef [TAPS];
  longint hist [$];
  bit     mov [2];
  exp_t   sb0 [$];
  exp_t   sb1 [$];

  cic_comp_fir #(.TAPS(TAPS), .DECIM(1)) u_d1 (
    .clock(clk), .reset(reset),
    .in_strobe(in_strobe), .in_data(in_data),
    .coef_wr(coef_wr), .coef_addr(coef_addr),
    .coef_data(coef_data), .overrun_clr(overrun_clr),
    .out_strobe(os[0]), .out_data(od[0]),
    .busy(busy[0]), .overrun(ov[0])
  );

  cic_comp_fir #(.TAPS(TAPS), .DECIM(2)) u_d2 (
    .clock(clk), .reset(reset),
    .in_strobe(in_strobe), .in_data(in_data),
    .coef_wr(coef_wr), .coef_addr(coef_addr),
    .coef_data(coef_data), .overrun_clr(overrun_clr),
    .out_strobe(os[1]), .out_data(od[1]),
    .busy(busy[1]), .overrun(ov[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : mon0
    exp_t e;
    if (os[0]) begin
      checks++;
      if (sb0.size() == 0) begin
        errors++;
        $display("FAIL d1_unexpected_strobe cyc=%0d", cyc);
      end else begin
        e = sb0.pop_front();
        if (od[0] !== e.data) begin
          errors++;
          $display("FAIL d1_data got=%0d exp=%0d cyc=%0d",
                   $signed(od[0]), $signed(e.data), cyc);
        end
        checks++;
        if (cyc !== e.cyc) begin
          errors++;
          $display("FAIL d1_latency got_cyc=%0d exp_cyc=%0d",
                   cyc, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (os[1]) begin
      checks++;
      if (sb1.size() == 0) begin
        errors++;
        $display("FAIL d2_unexpected_strobe cyc=%0d", cyc);
      end else begin
        e = sb1.pop_front();
        if (od[1] !== e.data) begin
          errors++;
          $display("FAIL d2_data got=%0d exp=%0d cyc=%0d",
                   $signed(od[1]), $signed(e.data), cyc);
        end
        checks++;
        if (cyc !== e.cyc) begin
          errors++;
          $display("FAIL d2_latency got_cyc=%0d exp_cyc=%0d",
                   cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] expect_out();
    longint acc = 0;
    longint sh;
    int n = hist.size();
    for (int k = 0; k < TAPS; k++)
      if (n - 1 - k >= 0)
        acc += longint'(mcoef[k]) * hist[n-1-k];
    sh = acc >>> (CWD - 1);
`ifdef CIC_COMP_SAT_EN
    if (sh > 64'sd8388607) return 24'h7FFFFF;
    if (sh < -64'sd8388608) return 24'h800000;
`endif
    return sh[23:0];
  endfunction

  function automatic int sched(input exp_t q[$], input int n,
                               output bit drop);
    int mx = -1;
    drop = 0;
    foreach (q[j]) begin
      if (q[j].cyc - (TAPS + 3) > n) drop = 1;
      if (q[j].cyc > mx) mx = q[j].cyc;
    end
    if (mx >= n) return mx + TAPS + 4;
    return n + TAPS + 4;
  endfunction

  task automatic model_reset();
    sb0.delete();
    sb1.delete();
    hist.delete();
    mov[0] = 0;
    mov[1] = 0;
  endtask

  task automatic model_accept(input logic signed [23:0] d,
                              input logic clr);
    exp_t e;
    bit   drop;
    int   oc;
    if (cyc < clear_end) begin
      if (clr) begin
        mov[0] = 0;
        mov[1] = 0;
      end
    end else begin
      hist.push_back(longint'(d));
      e.data = expect_out();
      for (int i = 0; i < 2; i++) begin
        drop = 0;
        if (hist.size() % (i + 1) == 0) begin
          if (i == 0) oc = sched(sb0, cyc, drop);
          else        oc = sched(sb1, cyc, drop);
          e.cyc = oc;
          if (!drop) begin
            if (i == 0) sb0.push_back(e);
            else        sb1.push_back(e);
          end
        end
        if (drop) mov[i] = 1;
        else if (clr) mov[i] = 0;
      end
    end
  endtask

  task automatic send(input logic [23:0] d, input logic clr);
    in_strobe   = 1;
    in_data     = d;
    overrun_clr = clr;
    model_accept(d, clr);
    tick();
    in_strobe   = 0;
    overrun_clr = 0;
  endtask

  task automatic load_coef(input int mode);
    for (int k = 0; k < TAPS; k++) begin
      if (mode == 0)      mcoef[k] = (k + 1) * 1024;
      else if (mode == 1) mcoef[k] = 4096;
      else                mcoef[k] = 131071;
      coef_wr   = 1;
      coef_addr = 5'(k);
      coef_data = 18'(mcoef[k]);
      tick();
    end
    coef_wr = 0;
  endtask

  task automatic wait_drain();
    int b = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && b < 2000) begin
      tick();
      b++;
    end
    tick();
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout left_d1=%0d left_d2=%0d",
               sb0.size(), sb1.size());
    end
  endtask

  task automatic check_ov(input string tag);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ov[i] !== mov[i]) begin
        errors++;
        $display("FAIL %s_ov%0d got=%b exp=%b", tag, i, ov[i], mov[i]);
      end
    end
  endtask

  task automatic count_clear(input bit poke);
    int bc0 = 0;
    int bc1 = 0;
    clear_end = cyc + 64;
    for (int i = 0; i < 80; i++) begin
      in_strobe = poke && (i == 10);
      in_data   = 24'd777;
      if (poke && i == 10) model_accept(24'd777, 1'b0);
      @(negedge clk);
      if (busy[0]) bc0++;
      if (busy[1]) bc1++;
      tick();
    end
    in_strobe = 0;
    checks++;
    if (bc0 != 64 || bc1 != 64) begin
      errors++;
      $display("FAIL clear_busy got=%0d/%0d exp=64", bc0, bc1);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks += 4;
      if (os[i] !== 1'b0) begin
        errors++;
        $display("FAIL rst_strobe%0d got=%b exp=0", i, os[i]);
      end
      if (od[i] !== 24'd0) begin
        errors++;
        $display("FAIL rst_data%0d got=%h exp=0", i, od[i]);
      end
      if (busy[i] !== 1'b1) begin
        errors++;
        $display("FAIL rst_busy%0d got=%b exp=1", i, busy[i]);
      end
      if (ov[i] !== 1'b0) begin
        errors++;
        $display("FAIL rst_ov%0d got=%b exp=0", i, ov[i]);
      end
    end
    tick();
    reset = 0;
    model_reset();
    count_clear(0);
  endtask

  task automatic test_impulse();
    int t0;
    load_coef(0);
    t0 = cyc;
    send(24'd65536, 0);
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL imp_busy_start got=%b exp=1", busy[0]);
    end
    while (cyc < t0 + TAPS + 4) tick();
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL imp_busy_done got=%b exp=1", busy[0]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL imp_busy_idle got=%b exp=0", busy[0]);
    end
    while (cyc < t0 + 40) tick();
    for (int n = 1; n < 36; n++) begin
      send(24'd0, 0);
      repeat (39) tick();
    end
    wait_drain();
  endtask

  task automatic test_wrap();
    load_coef(1);
    for (int n = 0; n < 200; n++) begin
      send(24'd1000, 0);
      repeat (39) tick();
    end
    wait_drain();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (od[i] !== 24'd1000) begin
        errors++;
        $display("FAIL wrap_steady%0d got=%0d exp=1000", i, od[i]);
      end
    end
  endtask

  task automatic test_overrun();
    send(24'd11, 0);
    repeat (4) tick();
    send(24'd22, 0);
    repeat (4) tick();
    send(24'd33, 0);
    check_ov("ovr_set");
    checks++;
    if (ov[0] !== 1'b1) begin
      errors++;
      $display("FAIL ovr_d1_set got=%b exp=1", ov[0]);
    end
    wait_drain();
    overrun_clr = 1;
    mov[0] = 0;
    mov[1] = 0;
    tick();
    overrun_clr = 0;
    check_ov("ovr_clr");
    tick();
    send(24'd44, 0);
    repeat (4) tick();
    send(24'd55, 0);
    repeat (4) tick();
    send(24'd66, 1);
    check_ov("ovr_setwins");
    checks++;
    if (ov[0] !== 1'b1) begin
      errors++;
      $display("FAIL ovr_setwins_d1 got=%b exp=1", ov[0]);
    end
    wait_drain();
  endtask

  task automatic test_sat();
    logic [23:0] want;
`ifdef CIC_COMP_SAT_EN
    want = 24'h7FFFFF;
`else
    want = 24'hFFF7E0;
`endif
    load_coef(2);
    for (int n = 0; n < 40; n++) begin
      send(24'h7FFFFF, 0);
      repeat (39) tick();
    end
    wait_drain();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (od[i] !== want) begin
        errors++;
        $display("FAIL sat%0d got=%h exp=%h", i, od[i], want);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    tick();
    send(24'd5000, 0);
    repeat (10) tick();
    reset = 1;
    tick();
    reset = 0;
    model_reset();
    count_clear(1);
    load_coef(0);
    send(24'd65536, 0);
    repeat (39) tick();
    for (int n = 1; n < 4; n++) begin
      send(24'd0, 0);
      repeat (39) tick();
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_wrap();
    test_overrun();
    test_sat();
    test_reset_mid_run();
    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
